// File: rtl/key_svc_pkg.sv
// ---------------------------------------------------------------------------
// key_svc_pkg
// Shared definitions for the key IRQ servicer: the FSM state encoding, the
// edge-capture PIO register map and the interrupt mask value that is written
// to every slave after reset.
// ---------------------------------------------------------------------------
package key_svc_pkg;

  typedef enum logic [2:0] {
    ST_INIT,     // write one slave's interrupt mask per cycle
    ST_IDLE,     // bus idle, arbitrate among pending IRQs
    ST_CLEAR,    // clear the granted slave's edge capture
    ST_READ,     // read the granted slave's live key level
    ST_CAPTURE   // readdata valid, push the event
  } svc_state_e;

  // PIO register offsets
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Enables the interrupt for the single key bit of each slave
  localparam logic [31:0] MASK_INIT = 32'h1;

endpackage

// File: rtl/key_evt_fifo.sv
// ---------------------------------------------------------------------------
// key_evt_fifo
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// head_data whenever valid is high; a pop advances to the next entry. A push
// to a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is ignored (the caller detects the drop from full/pop).
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset, empties the FIFO
//   push       in   write push_data this cycle
//   push_data  in   WIDTH  entry to write
//   pop        in   consume the head entry (ignored when empty)
//   head_data  out  WIDTH  head entry, zero when empty
//   valid      out  FIFO non-empty
//   full       out  FIFO holds DEPTH entries
//   count      out  clog2(DEPTH)+1  occupancy
// ---------------------------------------------------------------------------
module key_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & valid;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; only the pointers and
  // count are, and the head output is masked to zero while empty, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/key_irq_servicer.sv
// ---------------------------------------------------------------------------
// key_irq_servicer
// Avalon-MM master that configures and services N_KEYS single-bit
// edge-capture key PIO slaves sharing one master port. After reset it writes
// each slave's interrupt mask, then round-robin arbitrates among pending
// slave IRQs. For each grant it clears the slave's edge capture, reads the
// live key level and pushes {key index, level} into an event FIFO drained by
// a ready/valid sink. A push into a full FIFO is dropped and flagged in the
// sticky overflow bit.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   enable        in   gates new grants; an ongoing service completes
//   irq_in        in   N_KEYS  per-slave interrupt outputs
//   pio_rd0       in   N_KEYS  bit 0 of each slave's registered readdata
//   m_chipselect  out  N_KEYS  one-hot slave select
//   m_address     out  2       slave register address
//   m_write_n     out  active-low write strobe
//   m_writedata   out  32      write data
//   evt_valid     out  event FIFO non-empty
//   evt_ready     in   sink accepts the head event
//   evt_key       out  clog2(N_KEYS)  key index of the head event
//   evt_level     out  key level of the head event
//   evt_count     out  clog2(FIFO_DEPTH)+1  FIFO occupancy
//   overflow      out  sticky, an event was dropped
//   ovf_clr       in   clears overflow (a drop in the same cycle wins)
// ---------------------------------------------------------------------------
module key_irq_servicer
  import key_svc_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_KEYS-1:0]             irq_in,
  input  logic [N_KEYS-1:0]             pio_rd0,
  output logic [N_KEYS-1:0]             m_chipselect,
  output logic [1:0]                    m_address,
  output logic                          m_write_n,
  output logic [31:0]                   m_writedata,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(N_KEYS)-1:0]     evt_key,
  output logic                          evt_level,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int KW = $clog2(N_KEYS);
  localparam int EW = KW + 1;

  svc_state_e       state;
  logic [KW-1:0]    init_idx;
  logic [KW-1:0]    grant;
  logic [KW-1:0]    last_grant;

  // Round-robin arbiter
  logic             arb_valid;
  logic [KW-1:0]    arb_idx;
  int               cand;

  // Event path
  logic             cap_push;
  logic [EW-1:0]    cap_data;
  logic [EW-1:0]    head_data;
  logic             fifo_full;
  logic             fifo_drop;

  // Search upward from last_grant+1, wrapping mod N_KEYS; the first pending
  // slave wins. last_grant itself is visited last.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= N_KEYS; i++) begin
      cand = (int'(last_grant) + i) % N_KEYS;
      if (!arb_valid && irq_in[cand[KW-1:0]]) begin
        arb_valid = 1'b1;
        arb_idx   = cand[KW-1:0];
      end
    end
  end

  // FSM with registered bus outputs. Each bus cycle is registered at the edge
  // that enters the state owning it, so CLEAR/READ drive the bus during their
  // own state cycle. INIT registers the write for init_idx on each edge, so
  // the write to slave k is on the bus in the k-th cycle after reset release
  // and the last one overlaps the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      init_idx     <= '0;
      grant        <= '0;
      last_grant   <= KW'(N_KEYS - 1);
      m_chipselect <= '0;
      m_address    <= ADDR_DATA;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      // Bus idle unless the branch below issues a transfer.
      m_chipselect <= '0;
      m_address    <= ADDR_DATA;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;

      case (state)
        ST_INIT: begin
          m_chipselect <= N_KEYS'(1) << init_idx;
          m_address    <= ADDR_MASK;
          m_write_n    <= 1'b0;
          m_writedata  <= MASK_INIT;
          if (init_idx == KW'(N_KEYS - 1)) begin
            state <= ST_IDLE;
          end else begin
            init_idx <= init_idx + 1'b1;
          end
        end

        ST_IDLE: begin
          if (enable && arb_valid) begin
            grant        <= arb_idx;
            m_chipselect <= N_KEYS'(1) << arb_idx;
            m_address    <= ADDR_EDGE;
            m_write_n    <= 1'b0;
            m_writedata  <= '0;
            state        <= ST_CLEAR;
          end
        end

        // The slave drops its irq at the edge closing CLEAR. An edge arriving
        // after that re-raises it and is picked up by a later grant.
        ST_CLEAR: begin
          m_chipselect <= N_KEYS'(1) << grant;
          m_address    <= ADDR_DATA;
          m_write_n    <= 1'b1;
          state        <= ST_READ;
        end

        // Slave registers readdata at the edge closing READ.
        ST_READ: begin
          state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          last_grant <= grant;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // The push is taken straight from state so the event is in the FIFO at the
  // edge closing CAPTURE; pio_rd0 only feeds FIFO data, never the bus.
  assign cap_push  = (state == ST_CAPTURE);
  assign cap_data  = {grant, pio_rd0[grant]};
  // Full implies valid, so evt_ready alone tells whether a pop frees space.
  assign fifo_drop = cap_push & fifo_full & ~evt_ready;

  key_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_push),
    .push_data (cap_data),
    .pop       (evt_ready),
    .head_data (head_data),
    .valid     (evt_valid),
    .full      (fifo_full),
    .count     (evt_count)
  );

  assign evt_key   = head_data[EW-1:1];
  assign evt_level = head_data[0];

  // Sticky drop flag; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_irq_servicer.sv
// ---------------------------------------------------------------------------
// tb_key_irq_servicer
// Directed bench for key_irq_servicer with N_KEYS = 4, FIFO_DEPTH = 8.
// A behavioural edge-capture PIO model answers the bus: mask writes enable
// irq, edge-register writes clear it, data reads register the key level.
// Expected events are queued when a service is provoked and compared when
// the sink pops them. Inputs change on the falling edge; outputs are sampled
// on the falling edge (scoreboard 1 time unit later so it sees this cycle's
// evt_ready).
// ---------------------------------------------------------------------------
module tb_key_irq_servicer;

  localparam int N_KEYS     = 4;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  irq_in;
  logic [3:0]  pio_rd0;
  logic [3:0]  m_chipselect;
  logic [1:0]  m_address;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_key;
  logic        evt_level;
  logic [3:0]  evt_count;
  logic        overflow;
  logic        ovf_clr;

  // Slave model stimulus and state
  logic [3:0]  edge_in;
  logic [3:0]  hold;
  logic [3:0]  key_level;
  logic [3:0]  irq_reg;
  logic [3:0]  mask_reg;
  logic [3:0]  rd_reg;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [2:0]  exp_q [$];

  always #5 clk = ~clk;

  key_irq_servicer #(
    .N_KEYS     (N_KEYS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .irq_in       (irq_in),
    .pio_rd0      (pio_rd0),
    .m_chipselect (m_chipselect),
    .m_address    (m_address),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_level    (evt_level),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Edge-capture PIO slaves
  always @(posedge clk) begin
    if (reset) begin
      irq_reg  <= '0;
      mask_reg <= '0;
      rd_reg   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_chipselect[k] && !m_write_n && m_address == 2'd3)
          irq_reg[k] <= 1'b0;
        else if (edge_in[k] || hold[k])
          irq_reg[k] <= 1'b1;
        if (m_chipselect[k] && !m_write_n && m_address == 2'd2)
          mask_reg[k] <= m_writedata[0];
        if (m_chipselect[k] && m_write_n && m_address == 2'd0)
          rd_reg[k] <= key_level[k];
      end
    end
  end

  assign irq_in  = irq_reg & mask_reg;
  assign pio_rd0 = rd_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every pop must match the oldest expected event.
  always @(negedge clk) begin
    #1;
    if (!reset && evt_valid && evt_ready) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_event", {29'd0, evt_key, evt_level}, {29'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clear(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_chipselect != '0 && m_address == 2'd3 && !m_write_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    hold    = '0;
    edge_in = '0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    repeat (N_KEYS + 1) @(negedge clk);
  endtask

  // One edge on slave k; returns at the cycle the event becomes visible.
  task automatic service_one(input logic [1:0] k, input logic lvl,
                             input bit expect_kept, input bit ready_in_capture);
    bit ok;
    key_level[k] = lvl;
    edge_in      = 4'b0001 << k;
    @(negedge clk);
    edge_in = '0;
    wait_clear(10, ok);
    check("svc_clear_seen", 32'(ok), 32'd1);
    if (ok) check("svc_clear_cs", 32'(m_chipselect), 32'(4'b0001 << k));
    @(negedge clk);                       // READ
    @(negedge clk);                       // CAPTURE
    if (ready_in_capture) evt_ready = 1'b1;
    if (expect_kept) exp_q.push_back({k, lvl});
    @(negedge clk);
    if (ready_in_capture) evt_ready = 1'b0;
  endtask

  logic [1:0] rr_key [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

  initial begin
    bit ok;
    int prev;
    int bad;
    reset     = 1'b1;
    enable    = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    edge_in   = '0;
    hold      = '0;
    key_level = '0;

    // ---- reset values
    repeat (2) @(negedge clk);
    check("rst_cs",       32'(m_chipselect), 32'd0);
    check("rst_addr",     32'(m_address),    32'd0);
    check("rst_write_n",  32'(m_write_n),    32'd1);
    check("rst_wdata",    m_writedata,       32'd0);
    check("rst_valid",    32'(evt_valid),    32'd0);
    check("rst_count",    32'(evt_count),    32'd0);
    check("rst_key_lvl",  32'({evt_key, evt_level}), 32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);

    // ---- INIT mask writes on cycles 0..3, idle bus at cycle 4
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("init_cs",      32'(m_chipselect), 32'(4'b0001 << k));
      check("init_addr",    32'(m_address),    32'd2);
      check("init_write_n", 32'(m_write_n),    32'd0);
      check("init_wdata",   m_writedata,       32'd1);
    end
    @(negedge clk);
    check("idle_cs",      32'(m_chipselect), 32'd0);
    check("idle_write_n", 32'(m_write_n),    32'd1);

    // ---- round robin with irq 1011 held
    key_level = 4'b1010;
    for (int s = 0; s < 6; s++) exp_q.push_back({rr_key[s], key_level[rr_key[s]]});
    hold      = 4'b1011;
    evt_ready = 1'b1;
    enable    = 1'b1;
    prev      = 0;
    for (int s = 0; s < 6; s++) begin
      wait_clear(40, ok);
      check("rr_clear_seen", 32'(ok), 32'd1);
      if (!ok) break;
      check("rr_grant", 32'(m_chipselect), 32'(4'b0001 << rr_key[s]));
      if (s > 0) check("rr_period", 32'(cyc - prev), 32'd4);
      prev = cyc;
    end
    enable = 1'b0;
    hold   = '0;
    repeat (6) @(negedge clk);
    check("rr_drained", 32'(exp_q.size()), 32'd0);
    evt_ready = 1'b0;
    do_reset();

    // ---- single irq on slave 2, latency walk
    enable    = 1'b1;
    key_level = 4'b0100;
    edge_in   = 4'b0100;
    @(negedge clk);                       // t: irq visible, FSM in IDLE
    edge_in = '0;
    check("lat_t_cs", 32'(m_chipselect), 32'd0);
    @(negedge clk);                       // t+1 CLEAR
    check("lat_clr_cs",    32'(m_chipselect), 32'b0100);
    check("lat_clr_addr",  32'(m_address),    32'd3);
    check("lat_clr_wr_n",  32'(m_write_n),    32'd0);
    check("lat_clr_wdata", m_writedata,       32'd0);
    @(negedge clk);                       // t+2 READ
    check("lat_rd_cs",     32'(m_chipselect), 32'b0100);
    check("lat_rd_addr",   32'(m_address),    32'd0);
    check("lat_rd_wr_n",   32'(m_write_n),    32'd1);
    @(negedge clk);                       // t+3 CAPTURE
    check("lat_cap_cs",    32'(m_chipselect), 32'd0);
    check("lat_cap_valid", 32'(evt_valid),    32'd0);
    @(negedge clk);                       // t+4
    check("lat_valid",     32'(evt_valid),    32'd1);
    check("lat_key",       32'(evt_key),      32'd2);
    check("lat_level",     32'(evt_level),    32'd1);
    exp_q.push_back({2'd2, 1'b1});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("lat_popped", 32'(evt_count), 32'd0);

    // ---- enable low blocks new grants
    enable    = 1'b0;
    key_level = 4'b0001;
    edge_in   = 4'b0001;
    @(negedge clk);
    edge_in = '0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_chipselect != '0) bad++;
    end
    check("en_blocks", 32'(bad), 32'd0);
    exp_q.push_back({2'd0, 1'b1});
    evt_ready = 1'b1;
    enable    = 1'b1;
    wait_clear(10, ok);
    check("en_resume", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    evt_ready = 1'b0;
    check("en_drained", 32'(exp_q.size()), 32'd0);
    do_reset();

    // ---- overflow: 9 services into an 8-deep FIFO with no sink
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      service_one(2'(i % 4), i[0], i < 8, 1'b0);
      if (i == 7) begin
        check("ovf_cnt8",   32'(evt_count), 32'd8);
        check("ovf_before", 32'(overflow),  32'd0);
      end
    end
    check("ovf_count", 32'(evt_count), 32'd8);
    check("ovf_set",   32'(overflow),  32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow),  32'd0);
    check("ovf_keep8",   32'(evt_count), 32'd8);
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    evt_ready = 1'b0;
    check("ovf_drained",  32'(exp_q.size()), 32'd0);
    check("ovf_empty",    32'(evt_count),    32'd0);

    // ---- full FIFO, pop in the CAPTURE cycle accepts the push
    for (int i = 0; i < 8; i++) service_one(2'(3 - (i % 4)), ~i[0], 1'b1, 1'b0);
    check("fp_full", 32'(evt_count), 32'd8);
    service_one(2'd1, 1'b1, 1'b1, 1'b1);
    check("fp_count",    32'(evt_count), 32'd8);
    check("fp_no_ovf",   32'(overflow),  32'd0);
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    evt_ready = 1'b0;
    check("fp_drained", 32'(exp_q.size()), 32'd0);

    // ---- reset during READ
    service_one(2'd0, 1'b1, 1'b1, 1'b0);
    check("rr_pre_count", 32'(evt_count), 32'd1);
    key_level[1] = 1'b1;
    edge_in      = 4'b0010;
    @(negedge clk);
    edge_in = '0;
    wait_clear(10, ok);
    check("mid_clear_seen", 32'(ok), 32'd1);
    @(negedge clk);                       // READ
    check("mid_read_cs", 32'(m_chipselect), 32'b0010);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("mid_cs",      32'(m_chipselect), 32'd0);
    check("mid_write_n", 32'(m_write_n),    32'd1);
    check("mid_valid",   32'(evt_valid),    32'd0);
    check("mid_count",   32'(evt_count),    32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_init_cs",   32'(m_chipselect), 32'(4'b0001 << k));
      check("mid_init_addr", 32'(m_address),    32'd2);
    end
    repeat (8) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/key_irq_servicer.md
# key_irq_servicer

Avalon-MM master that configures and services up to N single-bit edge-capture key PIO slaves sharing one master port. After reset it writes every slave's interrupt mask. It then arbitrates round-robin among asserted slave IRQs; for each granted slave it clears the edge capture and reads back the live key level. Each result is pushed as a key event into an internal FIFO consumed by a ready/valid sink.

## Interface
- N_KEYS, 4: number of PIO slaves serviced (2..16)
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, no new grant; a service in progress completes
- irq_in  in  N_KEYS  per-slave irq outputs
- pio_rd0  in  N_KEYS  bit 0 of each slave's readdata (registered in slave, 1-cycle read latency)
- m_chipselect  out  N_KEYS  one-hot slave select
- m_address  out  2  slave register address
- m_write_n  out  1  active-low write strobe
- m_writedata  out  32  write data
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  sink accepts head entry
- evt_key  out  clog2(N_KEYS)  key index of head event
- evt_level  out  1  key level read after clear
- evt_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears overflow

## Operation
- States: INIT, IDLE, CLEAR, READ, CAPTURE.
- INIT: one cycle per slave k = 0..N_KEYS-1 with m_chipselect = 1<<k, m_address = 2, m_write_n = 0, m_writedata = 32'h1. After k = N_KEYS-1, go to IDLE.
- IDLE: bus idle. If enable and any irq_in bit is set, grant the first set bit searching upward from last_grant+1, wrapping mod N_KEYS, and go to CLEAR.
- CLEAR: chipselect(grant), address 3, write_n 0, writedata 0. The slave's edge capture and its irq drop at the closing edge.
- READ: chipselect(grant), address 0, write_n 1.
- CAPTURE: bus idle. Sample pio_rd0[grant] into evt_level. Push {grant, level}. Update last_grant = grant. Go to IDLE.
- Bus idle means chipselect 0, address 0, write_n 1, writedata 0.
- Push when full: drop the event and set overflow. The FSM does not stall.
- Push and pop in the same cycle: count is unchanged. When the FIFO is full, a simultaneous pop frees space and the push is accepted.
- A pop occurs when evt_valid & evt_ready.
- ovf_clr and a drop in the same cycle: overflow stays set (set wins).
- An edge arriving at the granted slave between CLEAR and READ re-raises its irq. It is serviced on a later grant; no event is lost.
- last_grant resets to N_KEYS-1, so slave 0 has first priority after reset.

## Timing
- Reset values:
  - FSM in INIT, k = 0.
  - Outputs: m_chipselect 0, m_address 0, m_write_n 1, m_writedata 0.
  - FIFO empty, evt_valid 0, evt_count 0, evt_key 0, evt_level 0, overflow 0.
- All outputs are registered or driven from state; no combinational path from inputs to bus outputs.
- Reset mid-operation (any state) returns to INIT next cycle, empties the FIFO and re-writes all masks.
- INIT lasts N_KEYS cycles; the first IDLE is cycle N_KEYS after reset release.
- Service latency: irq sampled in IDLE at cycle t; CLEAR t+1; READ t+2; CAPTURE t+3; evt_valid high at t+4 (FIFO empty, no overflow).
- Minimum service period is 4 cycles per event.
- FIFO is first-word-fall-through: head data is valid whenever evt_valid is high.

## Structure
- Package key_svc_pkg holds:
  - state enum
  - PIO register offsets ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3
  - MASK_INIT = 32'h1
- Sub-module key_evt_fifo: synchronous FWFT FIFO, parameterised width and depth, with count output.
- The FSM and round-robin arbiter live in the top level.

## Test plan
- Reset, N_KEYS = 4: four mask writes, address 2, writedata 1, chipselect 0001→0010→0100→1000 on cycles 0..3; IDLE at cycle 4.
- irq_in = 0100 at t with pio_rd0[2] = 1: CLEAR writes address 3 to slave 2 at t+1, READ at t+2, evt_valid at t+4 with evt_key 2, evt_level 1.
- irq_in = 1011 held (slave model drops irq on clear, re-asserts one cycle later): grant order 0,1,3,0,1,3; events arrive in that order.
- evt_ready = 0 with FIFO_DEPTH = 8 and 9 services: evt_count 8, overflow 1, first 8 events intact. Then ovf_clr: overflow 0.
- FIFO full, evt_ready = 1 in the CAPTURE cycle: no drop, evt_count stays 8, overflow stays 0.
- reset pulsed during READ: bus idle next cycle, FIFO empty, INIT mask writes replay from slave 0.
